energy_ratio_calc: RTL
======================

Name: energy_ratio_calc

Overview:
- Upstream feeder of the pulse matcher. Converts a signed sample stream into two sliding-window energy ratios: fb_ratio (front/back) and bf_ratio (back/front).
- The pulse matcher thresholds these ratios to detect pulse rise and fall.
- Each accepted sample updates two adjacent 64-sample power windows. Both ratios are then computed by sequential dividers. Results are held between updates.

Parameters:
- WIN, 64, samples per window; power of two; delay line depth is 2*WIN.
- PWR_SHIFT, 14, right shift applied to din^2 before saturation to 16 bits.
- FRAC_BITS, 0, fractional bits in the ratio outputs; range 0..4.
- RATIO_MAX, 1023, saturation value of both ratio outputs.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- din  in  16  signed sample.
- din_valid  in  1  sample strobe.
- din_ready  out  1  high when a sample can be accepted.
- fb_ratio  out  10  floor((front_sum<<FRAC_BITS)/back_sum), saturated.
- bf_ratio  out  10  floor((back_sum<<FRAC_BITS)/front_sum), saturated.
- ratio_valid  out  1  one-cycle pulse when the ratios update.
- windows_full  out  1  high once 2*WIN samples have been accepted since reset.

Behaviour:
- Reset (rst_n low at clk edge): fb_ratio=0, bf_ratio=0, ratio_valid=0, windows_full=0, din_ready=1. Sums, fill_cnt, write pointer and divider state are cleared. RAM contents are not cleared.
- Accept: a sample is accepted on a cycle with din_valid && din_ready (cycle A). din_valid while din_ready=0 is ignored; the sample is dropped and no error is flagged.
- din_ready is 0 from A+1 through A+13 and 1 from A+14. The minimum accept spacing is therefore 14 cycles.
- Power: p = sat16((din*din) >> PWR_SHIFT), unsigned. din=-32768 gives 65536, which saturates to 65535.
- Delay line: circular buffer of 2*WIN x 16 bits. Taps: p_mid is the sample written WIN accepts ago; p_old is the sample written 2*WIN accepts ago (read-before-write at wr_ptr). wr_ptr wraps modulo 2*WIN.
- Fill gating: fill_cnt saturates at 2*WIN. p_mid is treated as 0 while fill_cnt<WIN; p_old is treated as 0 while fill_cnt<2*WIN.
- Sums at A+1, each 22 bits unsigned: front_sum += p - p_mid; back_sum += p_mid - p_old. The sums can never go negative.
- Dividers load at A+2. Both dividers run concurrently: restoring division, 10 iterations covering A+3..A+12.
- Divider pre-check at load: if den==0, q = (num==0) ? 0 : RATIO_MAX. If (num<<FRAC_BITS) >= (den<<10), q = RATIO_MAX.
- Output at A+13: fb_ratio and bf_ratio are registered and ratio_valid pulses. Outputs hold until the next update.
- While windows_full=0, both ratios are forced to 0 but ratio_valid still pulses.
- windows_full rises in the A+13 cycle of the 2*WIN-th accept.
- Reset mid-pipeline aborts the operation. The next 2*WIN-1 results after reset are 0.

Decomposition:
- Package energy_ratio_pkg:
  - Constants: WIN default, SUM_W = 16+log2(WIN), RATIO_W = 10, RATIO_MAX, LATENCY = 13.
  - Pipeline-stage enum: IDLE, SUM, LOAD, DIV, OUT.
- One sub-module, ratio_divider: restoring divider with 10-bit quotient, zero-denominator and overflow saturation, start/done handshake. It is instantiated twice.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> all outputs 0, din_ready=1. Then 1 sample -> ratio_valid pulses exactly 13 cycles after accept with ratios 0.
- Steady tone: din=1000 for 200 accepts (p=61) -> results 1..127 are 0, windows_full rises on result 128, fb_ratio=bf_ratio=1 from result 128 onward.
- Step up:
  - 128 accepts of din=256 (p=4), then 64 of din=4096 (p=1024).
  - Result 192 -> fb_ratio=256 (65536/256), bf_ratio=0.
  - Then 64 of din=256 -> result 256: front_sum=256, back_sum=65536 -> fb_ratio=0, bf_ratio=256.
- Saturation and zero:
  - 128 accepts of din=0 -> ratios 0 (0/0).
  - Then 1 accept of din=-32768 -> fb_ratio=1023, bf_ratio=0.
- Handshake: din_valid held high continuously -> accepts exactly every 14 cycles, din_ready low for 13 cycles after each accept, no double accept.
- Reset mid-operation:
  - After windows_full=1, assert rst_n=0 for 1 cycle at A+6.
  - No ratio_valid for that sample; outputs 0, windows_full=0.
  - Next 127 results are 0; result 128 is valid.

Source files
------------

// File: rtl/energy_ratio_pkg.sv
// ============================================================================
// energy_ratio_pkg
// Shared constants, pipeline-stage encoding and helpers for energy_ratio_calc.
// Revision: 1.0
// ============================================================================
`default_nettype none

package energy_ratio_pkg;

    localparam int WIN_DEF       = 64;
    localparam int SUM_W         = 16 + $clog2(WIN_DEF);
    localparam int RATIO_W       = 10;
    localparam int RATIO_MAX_DEF = 1023;
    localparam int LATENCY       = 13;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SUM  = 3'd1,
        ST_LOAD = 3'd2,
        ST_DIV  = 3'd3,
        ST_OUT  = 3'd4
    } stage_t;

    // Clamp a 32-bit unsigned value into 16 bits.
    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (|v[31:16]) ? 16'hFFFF : v[15:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/energy_ratio_calc_divider.sv
// ============================================================================
// ratio_divider
// Restoring divider producing a 10-bit quotient of (num<<FRAC_BITS)/den with
// zero-denominator and overflow saturation. Fixed 10-cycle run after start.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ratio_divider #(
    parameter int NUM_W     = 22,
    parameter int FRAC_BITS = 0,
    parameter int RATIO_MAX = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [NUM_W-1:0] den,
    output logic             done,
    output logic [9:0]       q
);

    localparam int DW    = NUM_W + FRAC_BITS;  // scaled dividend width
    localparam int CW    = NUM_W + 10;         // width for the overflow compare
    localparam int REM_W = NUM_W + 1;          // remainder never exceeds 2*den

    logic [DW-1:0]    dividend;
    logic             ovf;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_shift;
    logic [9:0]       low;
    logic [9:0]       quo;
    logic [NUM_W-1:0] den_r;
    logic [3:0]       cnt;
    logic             fixed;
    logic [9:0]       fix_val;

    assign dividend  = DW'(num) << FRAC_BITS;
    assign ovf       = CW'(dividend) >= {den, 10'b0};
    assign rem_shift = {rem[REM_W-2:0], low[9]};
    assign q         = fixed ? fix_val : quo;

    // Load operands on start, then one restoring step per cycle for 10 cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem     <= '0;
            low     <= '0;
            quo     <= '0;
            den_r   <= '0;
            cnt     <= '0;
            fixed   <= 1'b0;
            fix_val <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Upper dividend bits are already below den once overflow is excluded.
                rem     <= REM_W'(dividend >> 10);
                low     <= dividend[9:0];
                quo     <= '0;
                den_r   <= den;
                cnt     <= 4'd10;
                fixed   <= (den == '0) || ovf;
                fix_val <= ((den == '0) && (num == '0)) ? 10'd0 : 10'(RATIO_MAX);
            end else if (cnt != 4'd0) begin
                if (rem_shift >= {1'b0, den_r}) begin
                    rem <= rem_shift - {1'b0, den_r};
                    quo <= {quo[8:0], 1'b1};
                end else begin
                    rem <= rem_shift;
                    quo <= {quo[8:0], 1'b0};
                end
                low <= {low[8:0], 1'b0};
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/energy_ratio_calc.sv
// ============================================================================
// energy_ratio_calc
// Sliding dual-window power sums and front/back, back/front energy ratios.
// Revision: 1.0
// ============================================================================
`default_nettype none

module energy_ratio_calc
    import energy_ratio_pkg::*;
#(
    parameter int WIN       = WIN_DEF,
    parameter int PWR_SHIFT = 14,
    parameter int FRAC_BITS = 0,
    parameter int RATIO_MAX = RATIO_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [RATIO_W-1:0] fb_ratio,
    output logic [RATIO_W-1:0] bf_ratio,
    output logic               ratio_valid,
    output logic               windows_full
);

    localparam int DEPTH = 2 * WIN;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int SW    = 16 + $clog2(WIN);
    localparam logic [FW-1:0] WIN_CNT   = FW'(WIN);
    localparam logic [FW-1:0] DEPTH_CNT = FW'(DEPTH);
    localparam logic [AW-1:0] WIN_OFS   = AW'(WIN);

    stage_t state, state_nxt;

    logic [15:0]        ram [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [FW-1:0]      fill_cnt;
    logic signed [31:0] din_ext;
    logic signed [31:0] sq;
    logic [31:0]        sq_sh;
    logic [15:0]        p_new;
    logic [15:0]        p_reg, p_mid_reg, p_old_reg;
    logic [SW-1:0]      front_sum, back_sum;
    logic               accept;
    logic               div_start;
    logic               fb_done, bf_done;
    logic [9:0]         fb_q, bf_q;
    logic               full_now;

    assign din_ext  = 32'(signed'(din));
    assign sq       = din_ext * din_ext;
    assign sq_sh    = sq >> PWR_SHIFT;
    assign p_new    = sat16(sq_sh);
    assign accept   = din_valid && din_ready;
    assign full_now = (fill_cnt == DEPTH_CNT);

    // Delay-line write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ram[wr_ptr] <= p_new;
        end
    end

    // Capture power and gated taps (read before write) on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            p_reg     <= '0;
            p_mid_reg <= '0;
            p_old_reg <= '0;
        end else if (accept) begin
            p_reg     <= p_new;
            p_mid_reg <= (fill_cnt >= WIN_CNT) ? ram[wr_ptr - WIN_OFS] : 16'd0;
            p_old_reg <= full_now ? ram[wr_ptr] : 16'd0;
            wr_ptr    <= wr_ptr + AW'(1);
            if (!full_now) begin
                fill_cnt <= fill_cnt + FW'(1);
            end
        end
    end

    // Slide both windows by one sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            front_sum <= '0;
            back_sum  <= '0;
        end else if (state == ST_SUM) begin
            front_sum <= front_sum + SW'(p_reg) - SW'(p_mid_reg);
            back_sum  <= back_sum + SW'(p_mid_reg) - SW'(p_old_reg);
        end
    end

    ratio_divider #(
        .NUM_W     (SW),
        .FRAC_BITS (FRAC_BITS),
        .RATIO_MAX (RATIO_MAX)
    ) u_fb_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (front_sum),
        .den   (back_sum),
        .done  (fb_done),
        .q     (fb_q)
    );

    ratio_divider #(
        .NUM_W     (SW),
        .FRAC_BITS (FRAC_BITS),
        .RATIO_MAX (RATIO_MAX)
    ) u_bf_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (back_sum),
        .den   (front_sum),
        .done  (bf_done),
        .q     (bf_q)
    );

    // Pipeline stage register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage sequencing; a new sample may enter while the result is presented.
    always_comb begin
        state_nxt = state;
        din_ready = 1'b0;
        div_start = 1'b0;
        case (state)
            ST_IDLE, ST_OUT: begin
                din_ready = 1'b1;
                state_nxt = din_valid ? ST_SUM : ST_IDLE;
            end
            ST_SUM:  state_nxt = ST_LOAD;
            ST_LOAD: begin
                div_start = 1'b1;
                state_nxt = ST_DIV;
            end
            ST_DIV:  state_nxt = (fb_done && bf_done) ? ST_OUT : ST_DIV;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Register ratios when both dividers finish; zero until windows are full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_ratio     <= '0;
            bf_ratio     <= '0;
            ratio_valid  <= 1'b0;
            windows_full <= 1'b0;
        end else begin
            ratio_valid <= 1'b0;
            if ((state == ST_DIV) && fb_done && bf_done) begin
                fb_ratio     <= full_now ? fb_q : '0;
                bf_ratio     <= full_now ? bf_q : '0;
                windows_full <= full_now;
                ratio_valid  <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
